sdram_arbiter: RTL and testbench

- Shares the single-port SDRAM controller between two requesters (port 0, port 1).
- Arbitrates round-robin and latches the winner's start address and word count.
- Drives the controller's write_en/read_en/address, and steers the winner's FIFO strobes onto the controller's write/read FIFOs while counting words.
- Flushes over-fetched read data, and sits in the system clock domain between DMA/bus masters and the SDRAM controller.

---
 rtl/sdram_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller between two ports; grant 1 cycle after req.
// Acks are combinational (stalled by FIFO full/empty); drain/flush gated by synchronized ready, timeout aborts.
module sdram_arbiter #(
  parameter int LEN_W        = 8,
  parameter int TIMEOUT      = 65535,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [1:0]       req_we,
  input  logic [21:0]      req_addr0,
  input  logic [21:0]      req_addr1,
  input  logic [LEN_W-1:0] req_len0,
  input  logic [LEN_W-1:0] req_len1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [1:0]       err,
  input  logic [1:0]       wr_stb,
  output logic [1:0]       wr_ack,
  input  logic [1:0]       rd_stb,
  output logic [1:0]       rd_ack,
  output logic             mem_write_en,
  output logic             mem_read_en,
  output logic [21:0]      mem_address,
  input  logic             mem_ready,
  output logic             mem_wr_fifo_wr,
  input  logic             mem_wr_fifo_full,
  output logic             mem_rd_fifo_rd,
  input  logic             mem_rd_fifo_empty,
  output logic             mem_rd_fifo_reset
);

  localparam int CNT_W = LEN_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int FL_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, WR_XFER, WR_DRAIN, RD_XFER, RD_FLUSH} state_t;

  state_t           state, state_nxt;
  logic             sync1, rdy_s;
  logic             last_ptr, gsel, abort, rdy_run;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] cnt, len_eff;
  logic [TMO_W-1:0] tmo;
  logic [FL_W-1:0]  fcnt;

  logic win, start, ack, last_word, tmo_hit, fin, fin_err, flush_go, abort_set;

  // A zero length means the full 2^LEN_W words, hence the extra count bit.
  assign len_eff   = (len_q == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_q};
  assign last_word = ((cnt + CNT_W'(1)) == len_eff);
  assign tmo_hit   = (tmo == TMO_W'(TIMEOUT - 1));
  assign win       = (req[0] & req[1]) ? ~last_ptr : req[1];

  always_comb begin
    state_nxt      = state;
    start          = 1'b0;
    ack            = 1'b0;
    fin            = 1'b0;
    fin_err        = 1'b0;
    flush_go       = 1'b0;
    abort_set      = 1'b0;
    wr_ack         = '0;
    rd_ack         = '0;
    mem_wr_fifo_wr = 1'b0;
    mem_rd_fifo_rd = 1'b0;
    mem_write_en   = 1'b0;
    mem_read_en    = 1'b0;
    case (state)
      IDLE: begin
        if (rdy_s && (req != 2'b00)) begin
          start     = 1'b1;
          state_nxt = req_we[win] ? WR_XFER : RD_XFER;
        end
      end
      WR_XFER: begin
        mem_write_en   = 1'b1;
        ack            = wr_stb[gsel] & ~mem_wr_fifo_full;
        mem_wr_fifo_wr = ack;
        wr_ack[gsel]   = ack;
        if (ack && last_word) begin
          state_nxt = WR_DRAIN;
        end else if (!ack && tmo_hit) begin
          fin       = 1'b1;
          fin_err   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WR_DRAIN: begin
        if (rdy_s && rdy_run) begin
          fin       = 1'b1;
          state_nxt = IDLE;
        end else if (!rdy_s && tmo_hit) begin
          fin       = 1'b1;
          fin_err   = 1'b1;
          state_nxt = IDLE;
        end
      end
      RD_XFER: begin
        mem_read_en    = 1'b1;
        ack            = rd_stb[gsel] & ~mem_rd_fifo_empty;
        mem_rd_fifo_rd = ack;
        rd_ack[gsel]   = ack;
        if (ack && last_word) begin
          state_nxt = RD_FLUSH;
        end else if (!ack && tmo_hit) begin
          // Aborted reads still flush, but without waiting for ready.
          flush_go  = 1'b1;
          abort_set = 1'b1;
          state_nxt = RD_FLUSH;
        end
      end
      RD_FLUSH: begin
        if (mem_rd_fifo_reset) begin
          if (fcnt == FL_W'(FLUSH_CYCLES - 1)) begin
            fin       = 1'b1;
            fin_err   = abort;
            state_nxt = IDLE;
          end
        end else if (rdy_s) begin
          flush_go = 1'b1;
        end else if (tmo_hit) begin
          flush_go  = 1'b1;
          abort_set = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      sync1             <= 1'b0;
      rdy_s             <= 1'b0;
      last_ptr          <= 1'b1;
      gsel              <= 1'b0;
      abort             <= 1'b0;
      rdy_run           <= 1'b0;
      len_q             <= '0;
      cnt               <= '0;
      tmo               <= '0;
      fcnt              <= '0;
      gnt               <= '0;
      done              <= '0;
      err               <= '0;
      mem_address       <= '0;
      mem_rd_fifo_reset <= 1'b0;
    end else begin
      sync1   <= mem_ready;
      rdy_s   <= sync1;
      state   <= state_nxt;
      done    <= '0;
      err     <= '0;
      rdy_run <= (state == WR_DRAIN) && rdy_s;

      if (ack || ((state == WR_DRAIN || state == RD_FLUSH) && rdy_s)) begin
        tmo <= '0;
      end else if (state != IDLE) begin
        tmo <= tmo + TMO_W'(1);
      end
      if (ack) cnt <= cnt + CNT_W'(1);

      if (start) begin
        gsel        <= win;
        last_ptr    <= win;
        gnt         <= win ? 2'b10 : 2'b01;
        mem_address <= win ? req_addr1 : req_addr0;
        len_q       <= win ? req_len1 : req_len0;
        cnt         <= '0;
        tmo         <= '0;
        abort       <= 1'b0;
      end

      if (abort_set) abort <= 1'b1;
      if (flush_go) begin
        mem_rd_fifo_reset <= 1'b1;
        fcnt              <= '0;
      end else if (mem_rd_fifo_reset) begin
        fcnt <= fcnt + FL_W'(1);
      end

      if (fin) begin
        gnt               <= '0;
        mem_rd_fifo_reset <= 1'b0;
        if (fin_err) err[gsel]  <= 1'b1;
        else         done[gsel] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: per-transaction monitor tallies acks/enables/flush and end timing.
module tb_sdram_arbiter;
  logic        clk, rst_n;
  logic [1:0]  req, req_we, gnt, done, err, wr_stb, wr_ack, rd_stb, rd_ack;
  logic [21:0] req_addr0, req_addr1, mem_address;
  logic [7:0]  req_len0, req_len1;
  logic        mem_write_en, mem_read_en, mem_ready;
  logic        mem_wr_fifo_wr, mem_wr_fifo_full, mem_rd_fifo_rd, mem_rd_fifo_empty, mem_rd_fifo_reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sdram_arbiter #(.LEN_W(8), .TIMEOUT(16), .FLUSH_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we),
    .req_addr0(req_addr0), .req_addr1(req_addr1), .req_len0(req_len0), .req_len1(req_len1),
    .gnt(gnt), .done(done), .err(err),
    .wr_stb(wr_stb), .wr_ack(wr_ack), .rd_stb(rd_stb), .rd_ack(rd_ack),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_address(mem_address),
    .mem_ready(mem_ready), .mem_wr_fifo_wr(mem_wr_fifo_wr), .mem_wr_fifo_full(mem_wr_fifo_full),
    .mem_rd_fifo_rd(mem_rd_fifo_rd), .mem_rd_fifo_empty(mem_rd_fifo_empty),
    .mem_rd_fifo_reset(mem_rd_fifo_reset)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-transaction tallies filled by run().
  logic        tog;
  int          m_ack0, m_ack1, m_wen, m_flush, m_bad, m_gcyc, m_ecyc;
  logic [1:0]  m_gnt, m_done, m_err, m_gnt_end;
  logic [21:0] m_addr;
  logic        m_wen_end;

  task automatic run(input int budget);
    logic [1:0] ack;
    m_ack0 = 0; m_ack1 = 0; m_wen = 0; m_flush = 0; m_bad = 0;
    m_gcyc = -1; m_ecyc = -1;
    m_gnt = '0; m_done = '0; m_err = '0; m_gnt_end = '0; m_addr = '0; m_wen_end = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      if (tog) mem_rd_fifo_empty = ~mem_rd_fifo_empty;
      #1;
      if (m_gcyc < 0 && gnt != 2'b00) begin
        m_gcyc = c;
        m_gnt  = gnt;
        m_addr = mem_address;
      end
      ack = wr_ack | rd_ack;
      m_ack0 += int'(ack[0]);
      m_ack1 += int'(ack[1]);
      m_wen  += int'(mem_write_en);
      m_flush += int'(mem_rd_fifo_reset);
      if ((ack & ~gnt) != 2'b00) m_bad++;
      if (rd_ack != 2'b00 && mem_rd_fifo_empty) m_bad++;
      if (wr_ack != 2'b00 && mem_wr_fifo_full) m_bad++;
      if (mem_wr_fifo_wr != (|wr_ack)) m_bad++;
      if (mem_rd_fifo_rd != (|rd_ack)) m_bad++;
      if ((done | err) != 2'b00) begin
        m_ecyc    = c;
        m_done    = done;
        m_err     = err;
        m_gnt_end = gnt;
        m_wen_end = mem_write_en;
        break;
      end
    end
    check("run_finished_in_budget", 32'(m_ecyc > 0), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; tog = 1'b0;
    req = '0; req_we = '0; req_addr0 = '0; req_addr1 = '0; req_len0 = '0; req_len1 = '0;
    wr_stb = '0; rd_stb = '0; mem_wr_fifo_full = 1'b0; mem_rd_fifo_empty = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_done_err", 32'({done, err}), 32'h0);
    check("rst_en", 32'({mem_write_en, mem_read_en}), 32'h0);
    check("rst_addr", 32'(mem_address), 32'h0);
    check("rst_flush", 32'(mem_rd_fifo_reset), 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;

    // Port 0 write, len 4
    req_we = 2'b01; req_addr0 = 22'h12345; req_len0 = 8'd4; wr_stb = 2'b01; req = 2'b01;
    run(40);
    check("w4_gnt_cyc", 32'(m_gcyc), 32'd1);
    check("w4_gnt", 32'(m_gnt), 32'h1);
    check("w4_addr", 32'(m_addr), 32'h12345);
    check("w4_acks0", 32'(m_ack0), 32'd4);
    check("w4_acks1", 32'(m_ack1), 32'd0);
    check("w4_wen_cycles", 32'(m_wen), 32'd4);
    check("w4_done_cyc", 32'(m_ecyc), 32'd7);
    check("w4_done", 32'(m_done), 32'h1);
    check("w4_err", 32'(m_err), 32'h0);
    check("w4_gnt_end", 32'(m_gnt_end), 32'h0);
    check("w4_bad", 32'(m_bad), 32'd0);
    req = 2'b00; wr_stb = 2'b00;

    // Both ports read from reset exit: round robin 0,1,0
    @(posedge clk); #2;
    rst_n = 1'b0;
    req_we = 2'b00; req_len0 = 8'd2; req_len1 = 8'd2;
    req_addr0 = 22'h100; req_addr1 = 22'h200;
    rd_stb = 2'b11; mem_rd_fifo_empty = 1'b0; req = 2'b11;
    @(posedge clk); #2;
    rst_n = 1'b1;
    run(60);
    check("rr1_gnt", 32'(m_gnt), 32'h1);
    check("rr1_addr", 32'(m_addr), 32'h100);
    check("rr1_acks0", 32'(m_ack0), 32'd2);
    check("rr1_flush", 32'(m_flush), 32'd4);
    check("rr1_done", 32'(m_done), 32'h1);
    run(60);
    check("rr2_gnt_cyc", 32'(m_gnt), 32'h2);
    check("rr2_gcyc", 32'(m_gcyc), 32'd1);
    check("rr2_addr", 32'(m_addr), 32'h200);
    check("rr2_acks1", 32'(m_ack1), 32'd2);
    check("rr2_done_cyc", 32'(m_ecyc), 32'd8);
    check("rr2_done", 32'(m_done), 32'h2);
    check("rr2_bad", 32'(m_bad), 32'd0);
    run(60);
    check("rr3_gnt", 32'(m_gnt), 32'h1);
    check("rr3_gcyc", 32'(m_gcyc), 32'd1);
    check("rr3_done", 32'(m_done), 32'h1);
    req = 2'b00; rd_stb = 2'b00; mem_rd_fifo_empty = 1'b1;

    // Port 1 read len 3 with empty toggling
    @(posedge clk); #2;
    req_we = 2'b00; req_addr1 = 22'h3abcd; req_len1 = 8'd3; rd_stb = 2'b11;
    tog = 1'b1; req = 2'b10;
    run(60);
    check("r3_gnt", 32'(m_gnt), 32'h2);
    check("r3_acks1", 32'(m_ack1), 32'd3);
    check("r3_acks0", 32'(m_ack0), 32'd0);
    check("r3_bad", 32'(m_bad), 32'd0);
    check("r3_flush", 32'(m_flush), 32'd4);
    check("r3_done", 32'(m_done), 32'h2);
    check("r3_err", 32'(m_err), 32'h0);
    tog = 1'b0; req = 2'b00; rd_stb = 2'b00; mem_rd_fifo_empty = 1'b1;

    // Write timeout with FIFO full stuck
    @(posedge clk); #2;
    req_we = 2'b01; req_addr0 = 22'h777; req_len0 = 8'd4; wr_stb = 2'b11;
    mem_wr_fifo_full = 1'b1; req = 2'b01;
    run(40);
    check("to_gcyc", 32'(m_gcyc), 32'd1);
    check("to_err", 32'(m_err), 32'h1);
    check("to_done", 32'(m_done), 32'h0);
    check("to_err_cyc", 32'(m_ecyc), 32'd17);
    check("to_acks", 32'(m_ack0 + m_ack1), 32'd0);
    check("to_gnt_end", 32'(m_gnt_end), 32'h0);
    check("to_wen_end", 32'(m_wen_end), 32'h0);
    req = 2'b00; wr_stb = 2'b00; mem_wr_fifo_full = 1'b0;
    @(posedge clk); #2;
    check("to_idle_gnt", 32'(gnt), 32'h0);
    check("to_idle_en", 32'({mem_write_en, mem_read_en, done, err}), 32'h0);

    // len 0 means 256 words
    req_we = 2'b10; req_addr1 = 22'h0ff00; req_len1 = 8'd0; wr_stb = 2'b10; req = 2'b10;
    run(400);
    check("l0_gcyc", 32'(m_gcyc), 32'd1);
    check("l0_acks1", 32'(m_ack1), 32'd256);
    check("l0_wen", 32'(m_wen), 32'd256);
    check("l0_done_cyc", 32'(m_ecyc), 32'd259);
    check("l0_done", 32'(m_done), 32'h2);
    check("l0_err", 32'(m_err), 32'h0);
    req = 2'b00; wr_stb = 2'b00;

    // Reset during a read transfer
    @(posedge clk); #2;
    req_we = 2'b00; req_addr0 = 22'h2468; req_len0 = 8'd10; rd_stb = 2'b01;
    mem_rd_fifo_empty = 1'b0; req = 2'b01;
    @(posedge clk); #2;
    check("rx_read_en", 32'(mem_read_en), 32'h1);
    check("rx_rd_ack", 32'(rd_ack), 32'h1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("rx_rst_gnt", 32'(gnt), 32'h0);
    check("rx_rst_en", 32'({mem_write_en, mem_read_en}), 32'h0);
    check("rx_rst_acks", 32'({rd_ack, wr_ack, mem_rd_fifo_rd, mem_wr_fifo_wr}), 32'h0);
    check("rx_rst_addr", 32'(mem_address), 32'h0);
    check("rx_rst_pulses", 32'({done, err, mem_rd_fifo_reset}), 32'h0);
    req = 2'b00; rd_stb = 2'b00; mem_rd_fifo_empty = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b1;
    req_we = 2'b01; req_addr0 = 22'h55; req_len0 = 8'd2; wr_stb = 2'b01; req = 2'b01;
    run(40);
    check("rx_new_gnt", 32'(m_gnt), 32'h1);
    check("rx_new_addr", 32'(m_addr), 32'h55);
    check("rx_new_acks0", 32'(m_ack0), 32'd2);
    check("rx_new_done", 32'(m_done), 32'h1);
    check("rx_new_err", 32'(m_err), 32'h0);
    req = 2'b00; wr_stb = 2'b00;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
